// File: rtl/mutex_requester_if.sv
// Handshake bundle between a mutex requester and its local client / arbiter side.
interface mutex_requester_if #(parameter int HOLD_W = 8);
  logic              start;
  logic [HOLD_W-1:0] hold_len;
  logic              grant;
  logic              req;
  logic              busy;
  logic              in_cs;
  logic              done;
  logic              timeout;
  logic              err;

  modport master (input start, hold_len, grant,
                  output req, busy, in_cs, done, timeout, err);
  modport slave  (output start, hold_len, grant,
                  input req, busy, in_cs, done, timeout, err);
endinterface

// File: rtl/mutex_requester.sv
// Mutex client: turns a start pulse into a request/grant/release handshake with tenure timer.
// Optional MUTEX_REQ_GRANT_SYNC_EN: 2-flop synchroniser on grant for a foreign arbiter clock.
//
// state   | meaning
// IDLE    | no transaction, start accepted
// REQ     | req high, waiting for grant (bounded by WAIT_MAX)
// HOLD    | critical section owned, tenure counting down
// RELEASE | req low, waiting for grant to drop
module mutex_requester #(
  parameter int HOLD_W   = 8,
  parameter int WAIT_W   = 10,
  parameter int WAIT_MAX = 500
) (
  input  logic               clk,
  input  logic               rst_n,
  mutex_requester_if.master  bus
);

  generate
    if (WAIT_MAX < 0 || WAIT_MAX >= (1 << WAIT_W)) begin : g_bad_wait_max
      $error("mutex_requester: WAIT_MAX must be below 2**WAIT_W");
    end
  endgenerate

  localparam logic [WAIT_W-1:0] WAIT_LIM = (WAIT_MAX == 0) ? '0 : WAIT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, RELEASE} state_t;

  state_t            state, state_n;
  logic              req_q;
  logic              abort, abort_n;
  logic              lost, lost_n;
  logic [HOLD_W-1:0] len;
  logic [HOLD_W-1:0] hold_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              done_c, timeout_c, err_c;
  logic              g_s;

`ifdef MUTEX_REQ_GRANT_SYNC_EN
  logic [1:0] grant_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_sync <= 2'b00;
    else        grant_sync <= {grant_sync[0], bus.grant};
  end
  assign g_s = grant_sync[1];
`else
  assign g_s = bus.grant;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      abort    <= 1'b0;
      lost     <= 1'b0;
      len      <= '0;
      hold_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      req_q <= (state_n == REQ) || (state_n == HOLD);
      abort <= abort_n;
      lost  <= lost_n;
      case (state)
        IDLE: begin
          if (bus.start) begin
            len      <= (bus.hold_len == '0) ? HOLD_W'(1) : bus.hold_len;
            wait_cnt <= '0;
          end
        end
        REQ: begin
          // saturate so an unbounded wait (WAIT_MAX=0) never wraps
          if (wait_cnt != '1) wait_cnt <= wait_cnt + WAIT_W'(1);
          if (g_s) hold_cnt <= len;
        end
        HOLD:    hold_cnt <= hold_cnt - HOLD_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    abort_n   = abort;
    lost_n    = lost;
    done_c    = 1'b0;
    timeout_c = 1'b0;
    err_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = REQ;
          abort_n = 1'b0;
          lost_n  = 1'b0;
        end
      end
      REQ: begin
        if (g_s) begin
          state_n = HOLD;
        end else if (WAIT_MAX != 0 && wait_cnt == WAIT_LIM) begin
          state_n = RELEASE;
          abort_n = 1'b1;
        end
      end
      HOLD: begin
        if (!g_s) begin
          err_c   = 1'b1;
          lost_n  = 1'b1;
          state_n = RELEASE;
        end else if (hold_cnt == HOLD_W'(1)) begin
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (!g_s) begin
          state_n   = IDLE;
          done_c    = !abort && !lost;
          timeout_c = abort && !lost;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.req     = req_q;
  assign bus.busy    = (state != IDLE);
  assign bus.in_cs   = (state == HOLD);
  assign bus.done    = done_c;
  assign bus.timeout = timeout_c;
  assign bus.err     = err_c;

endmodule

// File: tb/tb_mutex_requester.sv
// Scoreboard bench: one requester under directed grant control plus three sharing a 3-way mutex model.
module tb_mutex_requester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mutex_requester_if #(.HOLD_W(8)) m_if ();
  mutex_requester_if #(.HOLD_W(8)) a0_if ();
  mutex_requester_if #(.HOLD_W(8)) a1_if ();
  mutex_requester_if #(.HOLD_W(8)) a2_if ();

  mutex_requester #(.HOLD_W(8), .WAIT_W(10), .WAIT_MAX(8)) u_main (.clk(clk), .rst_n(rst_n), .bus(m_if));
  mutex_requester u_a0 (.clk(clk), .rst_n(rst_n), .bus(a0_if));
  mutex_requester u_a1 (.clk(clk), .rst_n(rst_n), .bus(a1_if));
  mutex_requester u_a2 (.clk(clk), .rst_n(rst_n), .bus(a2_if));

  // 3-way mutex model: owner keeps grant until its req drops, then lowest pending index wins
  logic [2:0] arb_req;
  logic [1:0] owner;
  assign arb_req = {a2_if.req, a1_if.req, a0_if.req};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) owner <= 2'd3;
    else if (owner == 2'd3 || !arb_req[owner]) begin
      if (arb_req[0])      owner <= 2'd0;
      else if (arb_req[1]) owner <= 2'd1;
      else if (arb_req[2]) owner <= 2'd2;
      else                 owner <= 2'd3;
    end
  end
  assign a0_if.grant = (owner == 2'd0);
  assign a1_if.grant = (owner == 2'd1);
  assign a2_if.grant = (owner == 2'd2);

  logic [3:0] m_req, m_cs, m_busy, m_done, m_to, m_err;
  assign m_req  = {a2_if.req,     a1_if.req,     a0_if.req,     m_if.req};
  assign m_cs   = {a2_if.in_cs,   a1_if.in_cs,   a0_if.in_cs,   m_if.in_cs};
  assign m_busy = {a2_if.busy,    a1_if.busy,    a0_if.busy,    m_if.busy};
  assign m_done = {a2_if.done,    a1_if.done,    a0_if.done,    m_if.done};
  assign m_to   = {a2_if.timeout, a1_if.timeout, a0_if.timeout, m_if.timeout};
  assign m_err  = {a2_if.err,     a1_if.err,     a0_if.err,     m_if.err};

  typedef struct { int kind; int cs; int rq; } exp_t;  // kind: 0 done, 1 timeout, 2 err
  exp_t exp_q [4][$];

  int checks = 0;
  int errors = 0;
  int mutex_viol = 0;

  task automatic check(input string name, input int ch, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s ch%0d got=%0d expected=%0d", name, ch, got, expv);
    end
  endtask

  task automatic expect_txn(input int ch, input int kind, input int cs, input int rq);
    exp_t e;
    e.kind = kind; e.cs = cs; e.rq = rq;
    exp_q[ch].push_back(e);
  endtask

  // monitor: accumulates req/in_cs cycles per channel and scores each completion pulse
  initial begin : monitor
    int   cs_cnt [4];
    int   rq_cnt [4];
    bit   chk_idle [4];
    exp_t e;
    int   kind;
    for (int c = 0; c < 4; c++) begin cs_cnt[c] = 0; rq_cnt[c] = 0; chk_idle[c] = 0; end
    forever begin
      @(negedge clk);
      if ($countones(m_cs[3:1]) > 1) mutex_viol++;
      for (int c = 0; c < 4; c++) begin
        if (!rst_n) begin
          cs_cnt[c] = 0; rq_cnt[c] = 0; chk_idle[c] = 0;
        end else begin
          if (chk_idle[c]) begin
            check("busy_after_end", c, int'(m_busy[c]), 0);
            chk_idle[c] = 0;
          end
          cs_cnt[c] += int'(m_cs[c]);
          rq_cnt[c] += int'(m_req[c]);
          if (m_done[c] || m_to[c] || m_err[c]) begin
            check("single_pulse", c, int'(m_done[c]) + int'(m_to[c]) + int'(m_err[c]), 1);
            kind = m_done[c] ? 0 : (m_to[c] ? 1 : 2);
            if (exp_q[c].size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_pulse ch%0d got kind=%0d expected no pulse", c, kind);
            end else begin
              e = exp_q[c].pop_front();
              check("pulse_kind", c, kind, e.kind);
              check("in_cs_cycles", c, cs_cnt[c], e.cs);
              check("req_cycles", c, rq_cnt[c], e.rq);
              if (kind != 2) check("busy_at_pulse", c, int'(m_busy[c]), 1);
            end
            if (kind != 2) chk_idle[c] = 1;
            cs_cnt[c] = 0; rq_cnt[c] = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start0(input logic [7:0] len);
    m_if.hold_len = len;
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
  endtask

  task automatic wait_req_low0();
    int n = 0;
    while (m_if.req && n < 60) begin tick(); n++; end
    if (m_if.req) check("req_fall_bound", 0, 1, 0);
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (m_if.busy && n < 60) begin tick(); n++; end
    if (m_if.busy) check("idle_bound", 0, 1, 0);
    tick(); tick();
  endtask

  // releases grant one cycle after req falls, then waits for completion
  task automatic release0();
    wait_req_low0();
    tick();
    m_if.grant = 1'b0;
    wait_idle0();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc;
    m_if.start = 0;  m_if.hold_len = 0;  m_if.grant = 0;
    a0_if.start = 0; a1_if.start = 0; a2_if.start = 0;
    a0_if.hold_len = 8'd5; a1_if.hold_len = 8'd5; a2_if.hold_len = 8'd5;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 0, int'(m_if.req), 0);
    check("rst_busy", 0, int'(m_if.busy), 0);
    check("rst_in_cs", 0, int'(m_if.in_cs), 0);
    check("rst_done", 0, int'(m_if.done), 0);
    check("rst_timeout", 0, int'(m_if.timeout), 0);
    check("rst_err", 0, int'(m_if.err), 0);
    rst_n = 1'b1;
    tick(); tick();

    // single transaction: grant seen in 3rd request cycle -> 3 REQ + 4 HOLD
    expect_txn(0, 0, 4, 7);
    start0(8'd4);
    tick(); tick();
    m_if.grant = 1'b1;
    release0();

    // zero tenure with grant already high
    m_if.grant = 1'b1;
    tick();
    expect_txn(0, 0, 1, 2);
    start0(8'd0);
    release0();

    // timeout after 8 request cycles
    expect_txn(0, 1, 0, 8);
    start0(8'd5);
    wait_idle0();

    // grant in the 8th request cycle wins over the timeout limit
    expect_txn(0, 0, 2, 10);
    start0(8'd2);
    repeat (7) tick();
    m_if.grant = 1'b1;
    release0();

    // grant lost in 2nd tenure cycle of 6
    m_if.grant = 1'b1;
    tick();
    expect_txn(0, 2, 2, 3);
    start0(8'd6);
    tick(); tick();
    m_if.grant = 1'b0;
    tick();
    check("req_after_err", 0, int'(m_if.req), 0);
    wait_idle0();

    // reset during tenure cycle 3, then a fresh transaction
    m_if.grant = 1'b1;
    tick();
    start0(8'd6);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 0, int'(m_if.req), 0);
    check("async_rst_in_cs", 0, int'(m_if.in_cs), 0);
    check("async_rst_busy", 0, int'(m_if.busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    expect_txn(0, 0, 3, 4);
    start0(8'd3);
    release0();

    // three requesters on the mutex model, common start, extra starts while busy
    expect_txn(1, 0, 5, 7);
    expect_txn(2, 0, 5, 14);
    expect_txn(3, 0, 5, 21);
    a0_if.start = 1; a1_if.start = 1; a2_if.start = 1;
    tick();
    a0_if.start = 0; a1_if.start = 0; a2_if.start = 0;
    cyc = 0;
    while (cyc < 40 && (a0_if.busy || a1_if.busy || a2_if.busy)) begin
      a0_if.start = (cyc == 3); a1_if.start = (cyc == 3); a2_if.start = (cyc == 3);
      tick();
      cyc++;
    end
    a0_if.start = 0; a1_if.start = 0; a2_if.start = 0;
    check("arb_all_idle_cycle", 1, cyc, 23);
    repeat (4) tick();
    check("arb_no_extra_txn", 1, int'(a0_if.busy) + int'(a1_if.busy) + int'(a2_if.busy), 0);
    check("mutex_violations", 1, mutex_viol, 0);

    for (int c = 0; c < 4; c++) check("scoreboard_drained", c, exp_q[c].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
